// File: rtl/door_lock_keypad_ctrl_if.sv
// Keypad-controller bundle: scanner/lock-state inputs and the pulse/status outputs.
// Ports: key_valid, key_code, state_in (towards the controller); ps_start, ps_end,
//   err, locked, digit_cnt (from the controller). master = stimulus side, slave = controller.
interface door_lock_keypad_ctrl_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic [1:0] state_in;
  logic       ps_start;
  logic       ps_end;
  logic       err;
  logic       locked;
  logic [2:0] digit_cnt;

  modport master (
    output key_valid, key_code, state_in,
    input  ps_start, ps_end, err, locked, digit_cnt
  );

  modport slave (
    input  key_valid, key_code, state_in,
    output ps_start, ps_end, err, locked, digit_cnt
  );
endinterface

// File: rtl/door_lock_keypad_ctrl.sv
// Keypad front end: turns debounced key strobes into ps_start/ps_end/err pulses,
//   counts wrong codes and enforces a timed lockout after MAX_FAIL misses.
// Ports: clk, rst (async active-low), bus (slave): key_valid/key_code/state_in in,
//   ps_start/ps_end/err (1-cycle pulses), locked (level), digit_cnt (0..7) out.
module door_lock_keypad_ctrl #(
  parameter int          CODE_LEN    = 4,
  parameter logic [27:0] PASSWORD    = 28'h1234,
  parameter int          TIMEOUT     = 50000,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCKOUT_CYC = 100000
) (
  input logic                   clk,
  input logic                   rst,
  door_lock_keypad_ctrl_if.slave bus
);

  localparam int BW = 4 * CODE_LEN;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LOCKOUT_CYC + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [BW-1:0] CODE     = PASSWORD[BW-1:0];
  localparam logic [2:0]    CL3      = 3'(CODE_LEN);
  // Loaded with N-1 so that expiry lands exactly N clocks after the load edge.
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LCK_LOAD = LW'(LOCKOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ENTRY, CHECK, LOCKOUT} state_t;

  state_t state, state_nxt;

  // key_valid synchroniser: sync[1:0] are the metastability stages, sync[2]
  // holds the previous synchronised level for edge detection.
  logic [2:0] sync;
  logic       kev;
  logic [3:0] code_q;

  logic [BW-1:0] code_buf, buf_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic          ovf, ovf_nxt;
  logic [FW-1:0] fail, fail_nxt, fail_inc;
  logic [TW-1:0] tmr, tmr_nxt;
  logic [LW-1:0] lck, lck_nxt;
  logic          start_q, start_nxt;
  logic          end_q, end_nxt;
  logic          err_q, err_nxt;

  logic is_digit, is_star, is_hash, match;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync   <= '0;
      kev    <= 1'b0;
      code_q <= '0;
    end else begin
      sync <= {sync[1:0], bus.key_valid};
      kev  <= sync[1] & ~sync[2];
      if (sync[1] & ~sync[2]) begin
        code_q <= bus.key_code;
      end
    end
  end

  assign is_digit = (code_q <= 4'd9);
  assign is_star  = (code_q == 4'hA);
  assign is_hash  = (code_q == 4'hB);
  assign match    = (cnt == CL3) && !ovf && (code_buf == CODE);
  assign fail_inc = fail + FW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      code_buf <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      fail     <= '0;
      tmr      <= '0;
      lck      <= '0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      code_buf <= buf_nxt;
      cnt      <= cnt_nxt;
      ovf      <= ovf_nxt;
      fail     <= fail_nxt;
      tmr      <= tmr_nxt;
      lck      <= lck_nxt;
      start_q  <= start_nxt;
      end_q    <= end_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    buf_nxt   = code_buf;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    fail_nxt  = fail;
    tmr_nxt   = (tmr != '0) ? tmr - TW'(1) : '0;
    lck_nxt   = (lck != '0) ? lck - LW'(1) : '0;
    start_nxt = 1'b0;
    end_nxt   = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        // Entries are refused while the door is open.
        if (kev && is_star && bus.state_in != 2'b10) begin
          state_nxt = ENTRY;
          buf_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          tmr_nxt   = TMR_LOAD;
          start_nxt = (bus.state_in == 2'b00);
        end
      end

      ENTRY: begin
        // Accepted keys take priority over a timer expiring in the same cycle;
        // codes C-F fall through and neither reload the timer nor block expiry.
        if (kev && is_digit) begin
          if (cnt < CL3) begin
            buf_nxt = (code_buf << 4) | BW'(code_q);
          end else begin
            ovf_nxt = 1'b1;
          end
          cnt_nxt = (cnt == 3'd7) ? 3'd7 : cnt + 3'd1;
          tmr_nxt = TMR_LOAD;
        end else if (kev && is_star) begin
          buf_nxt = '0;
          cnt_nxt = '0;
          ovf_nxt = 1'b0;
          tmr_nxt = TMR_LOAD;
        end else if (kev && is_hash) begin
          state_nxt = CHECK;
        end else if (tmr == '0) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end

      CHECK: begin
        if (match) begin
          end_nxt   = 1'b1;
          fail_nxt  = '0;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          err_nxt  = 1'b1;
          fail_nxt = fail_inc;
          buf_nxt  = '0;
          cnt_nxt  = '0;
          ovf_nxt  = 1'b0;
          if (fail_inc >= FW'(MAX_FAIL)) begin
            state_nxt = LOCKOUT;
            lck_nxt   = LCK_LOAD;
          end else begin
            state_nxt = ENTRY;
            tmr_nxt   = TMR_LOAD;
          end
        end
      end

      LOCKOUT: begin
        if (lck == '0) begin
          fail_nxt  = '0;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ps_start  = start_q;
  assign bus.ps_end    = end_q;
  assign bus.err       = err_q;
  assign bus.locked    = (state == LOCKOUT);
  assign bus.digit_cnt = cnt;

endmodule
